// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the unified memory port arbiter: IF requester, LSU requester and memory side.
// slave = arbiter side, master = the surrounding pipeline/memory (or a testbench).
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Fetch requester
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          i_flush_if;
  logic          o_if_ack;
  logic [DW-1:0] o_if_rdata;
  logic          o_if_stall;

  // Load/store requester
  logic          i_lsu_req;
  logic          i_lsu_we;
  logic [AW-1:0] i_lsu_addr;
  logic [DW-1:0] i_lsu_wdata;
  logic [3:0]    i_lsu_bmask;
  logic          o_lsu_ack;
  logic [DW-1:0] o_lsu_rdata;
  logic          o_lsu_stall;

  // Memory side
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [3:0]    o_mem_bmask;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ack;

  // Status / debug
  logic          o_err;
  logic [1:0]    o_dbg_state;

  modport slave (
    input  i_if_req, i_if_addr, i_flush_if,
    output o_if_ack, o_if_rdata, o_if_stall,
    input  i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_bmask,
    output o_lsu_ack, o_lsu_rdata, o_lsu_stall,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
    input  i_mem_rdata, i_mem_ack,
    output o_err, o_dbg_state
  );

  modport master (
    output i_if_req, i_if_addr, i_flush_if,
    input  o_if_ack, o_if_rdata, o_if_stall,
    output i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_bmask,
    input  o_lsu_ack, o_lsu_rdata, o_lsu_stall,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
    output i_mem_rdata, i_mem_ack,
    input  o_err, o_dbg_state
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, MEM priority with burst limiter.
// Optional ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
//
// Handshake: a requester holds req (and its address/data) until its 1-cycle ack pulse; the
// arbiter holds o_mem_req and all memory outputs stable until the 1-cycle i_mem_ack pulse.
module mem_port_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_MEM_BURST = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                i_clk,
  input  logic                i_reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_LSU = 2'd2,
    DRAIN_IF = 2'd3
  } state_t;

  localparam int BW = (MAX_MEM_BURST < 2) ? 1 : $clog2(MAX_MEM_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_MEM_BURST);

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] burst_cnt;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_bmask;

  logic          if_ok;
  logic          grant_lsu;
  logic          grant_if;
  logic          done;
  logic          tmo;
  logic          err;
  logic          if_ack;
  logic          lsu_ack;
  logic [DW-1:0] if_rdata;
  logic [DW-1:0] lsu_rdata;

  assign if_ok = bus.i_if_req & ~bus.i_flush_if;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_cnt;
  logic          err_q;

  // Counts cycles spent waiting on the memory; restarts every time the arbiter is idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE) wd_cnt <= '0;
      else               wd_cnt <= wd_cnt + 1'b1;
      if (tmo) err_q <= 1'b1;
    end
  end

  assign tmo = (state != IDLE) && !bus.i_mem_ack && (wd_cnt == TW'(TIMEOUT - 1));
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_lsu = 1'b0;
    grant_if  = 1'b0;
    done      = 1'b0;
    if_ack    = 1'b0;
    lsu_ack   = 1'b0;
    if_rdata  = '0;
    lsu_rdata = '0;
    case (state)
      IDLE: begin
        // The burst limiter only bites when a fetch could actually be granted this cycle.
        if (bus.i_lsu_req && !(if_ok && (burst_cnt == BURST_MAX))) begin
          grant_lsu = 1'b1;
          state_nxt = BUSY_LSU;
        end else if (if_ok) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF: begin
        if (bus.i_mem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
          if (!bus.i_flush_if) begin
            if_ack   = 1'b1;
            if_rdata = bus.i_mem_rdata;
          end
        end else if (tmo) begin
          done      = 1'b1;
          state_nxt = IDLE;
          if_ack    = !bus.i_flush_if;
        end else if (bus.i_flush_if) begin
          state_nxt = DRAIN_IF;
        end
      end
      BUSY_LSU: begin
        if (bus.i_mem_ack || tmo) begin
          done      = 1'b1;
          state_nxt = IDLE;
          lsu_ack   = 1'b1;
          if (bus.i_mem_ack) lsu_rdata = bus.i_mem_rdata;
        end
      end
      DRAIN_IF: begin
        if (bus.i_mem_ack || tmo) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_bmask <= 4'h0;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant_lsu) begin
        mem_req   <= 1'b1;
        mem_we    <= bus.i_lsu_we;
        mem_addr  <= bus.i_lsu_addr;
        mem_wdata <= bus.i_lsu_wdata;
        mem_bmask <= bus.i_lsu_bmask;
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= bus.i_if_addr;
        mem_wdata <= '0;
        mem_bmask <= 4'hF;
      end else if (done) begin
        mem_req   <= 1'b0;
      end
      // A granted LSU implies i_if_req is high here, so only pending-fetch grants are counted.
      if (!bus.i_if_req || grant_if) begin
        burst_cnt <= '0;
      end else if (grant_lsu && (burst_cnt != BURST_MAX)) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  assign bus.o_if_ack    = if_ack;
  assign bus.o_if_rdata  = if_rdata;
  assign bus.o_if_stall  = bus.i_if_req & ~if_ack;
  assign bus.o_lsu_ack   = lsu_ack;
  assign bus.o_lsu_rdata = lsu_rdata;
  assign bus.o_lsu_stall = bus.i_lsu_req & ~lsu_ack;
  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_bmask = mem_bmask;
  assign bus.o_err       = err;
  assign bus.o_dbg_state = state;

  // Structural invariants of the port.
  a_cfg: assert property (@(posedge i_clk) (MAX_MEM_BURST >= 1) && (TIMEOUT >= 1));
  a_ack_excl: assert property (@(posedge i_clk) disable iff (i_reset) !(if_ack && lsu_ack));
  a_req_state: assert property (@(posedge i_clk) disable iff (i_reset) mem_req == (state != IDLE));
  a_hold: assert property (@(posedge i_clk) disable iff (i_reset)
    (mem_req && !done) |=> ($stable(mem_addr) && $stable(mem_wdata) && $stable(mem_we)
                            && $stable(mem_bmask) && mem_req));

endmodule
